// File: rtl/demux_1to4_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4_dispatch
// Brief    : Valid/ready dispatcher with a 2-entry skid stage. Tags each word
//            with a channel and drives the 1-to-4 demux data, select and valid.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to4_dispatch #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] d_out,
    output logic [1:0]       sel_out,
    output logic [3:0]       ch_valid,
    input  logic [3:0]       ch_ready,
    output logic [31:0]      xfer_cnt
);

    logic             r_o_valid;
    logic [WIDTH-1:0] r_o_data;
    logic [1:0]       r_o_sel;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_data;
    logic [1:0]       r_s_sel;
    logic [1:0]       r_rr_ptr;
    logic [31:0]      r_xfer_cnt;

    logic             w_in_fire;
    logic             w_out_fire;
    logic [1:0]       w_tag;

    // The skid is only ever filled while the output register is occupied, so
    // a full skid alone means the stage is at capacity.
    assign in_ready   = ~r_s_valid & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_o_valid & ch_ready[r_o_sel];
    assign w_tag      = in_mode ? r_rr_ptr : in_dest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_valid  <= 1'b0;
            r_o_data   <= '0;
            r_o_sel    <= 2'd0;
            r_s_valid  <= 1'b0;
            r_s_data   <= '0;
            r_s_sel    <= 2'd0;
            r_rr_ptr   <= 2'd0;
            r_xfer_cnt <= 32'd0;
        end else begin
            if (w_in_fire && in_mode) begin
                r_rr_ptr <= r_rr_ptr + 2'd1;
            end
            if (w_out_fire) begin
                r_xfer_cnt <= r_xfer_cnt + 32'd1;
            end
            if (!r_o_valid || w_out_fire) begin
                if (r_s_valid) begin
                    r_o_valid <= 1'b1;
                    r_o_data  <= r_s_data;
                    r_o_sel   <= r_s_sel;
                    r_s_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_o_valid <= 1'b1;
                    r_o_data  <= in_data;
                    r_o_sel   <= w_tag;
                end else begin
                    r_o_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_s_valid <= 1'b1;
                r_s_data  <= in_data;
                r_s_sel   <= w_tag;
            end
        end
    end

    assign d_out    = r_o_valid ? r_o_data : '0;
    assign sel_out  = r_o_valid ? r_o_sel : 2'd0;
    assign ch_valid = r_o_valid ? (4'b0001 << r_o_sel) : 4'b0000;
    assign xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to4_dispatch
// Brief    : Self-checking bench: queue-based occupancy model plus directed
//            scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to4_dispatch;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       in_dest = 2'd0;
    logic             in_mode = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] d_out;
    logic [1:0]       sel_out;
    logic [3:0]       ch_valid;
    logic [3:0]       ch_ready = 4'h0;
    logic [31:0]      xfer_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    demux_1to4_dispatch #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .in_mode  (in_mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d_out    (d_out),
        .sel_out  (sel_out),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: the dispatcher is a FIFO of at most two tagged words; the head is
    // what the demux sees.
    typedef struct {
        logic [63:0] d;
        logic [1:0]  s;
    } word_t;

    word_t       mq[$];
    int unsigned m_rr = 0;
    logic [31:0] m_fires = 0;
    logic [31:0] m_base = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_rr = 0;
            m_fires = 0;
        end else begin
            bit acc, dep;
            word_t w;
            acc = in_valid && (mq.size() < 2);
            dep = (mq.size() > 0) && ch_ready[mq[0].s];
            if (dep) begin
                void'(mq.pop_front());
                m_fires = m_fires + 32'd1;
            end
            if (acc) begin
                w.d = in_data;
                w.s = in_mode ? 2'(m_rr % 4) : in_dest;
                if (in_mode) m_rr = m_rr + 1;
                mq.push_back(w);
            end
        end
    end

    always @(negedge clk) begin
        logic        e_rdy;
        logic [3:0]  e_cv;
        logic [1:0]  e_sel;
        logic [63:0] e_d;
        e_rdy = !rst && (mq.size() < 2);
        e_cv  = 4'b0000;
        e_sel = 2'd0;
        e_d   = 64'd0;
        if (mq.size() > 0) begin
            e_cv  = 4'b0001 << mq[0].s;
            e_sel = mq[0].s;
            e_d   = mq[0].d;
        end
        chk("model.in_ready", {63'd0, in_ready}, {63'd0, e_rdy});
        chk("model.ch_valid", {60'd0, ch_valid}, {60'd0, e_cv});
        chk("model.sel_out", {62'd0, sel_out}, {62'd0, e_sel});
        chk("model.d_out", d_out, e_d);
        chk("model.xfer_cnt", {32'd0, xfer_cnt}, {32'd0, m_base + m_fires});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic [1:0] dst, input logic md);
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dst;
        in_mode  = md;
    endtask

    logic [3:0] pat [16] = '{4'hF, 4'h0, 4'h2, 4'hF, 4'h0, 4'h0, 4'h8, 4'h1,
                             4'hF, 4'h4, 4'h0, 4'hF, 4'hA, 4'h5, 4'hF, 4'hF};

    initial begin
        #2;
        chk("reset.ch_valid", {60'd0, ch_valid}, 64'd0);
        chk("reset.in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset.d_out", d_out, 64'd0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("post_reset.in_ready", {63'd0, in_ready}, 64'd1);

        // Round-robin, all channels ready
        ch_ready = 4'hF;
        step();
        drive(64'd1, 2'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr.ch_valid", {60'd0, ch_valid}, 64'(4'b0001 << (i % 4)));
            chk("rr.d_out", d_out, 64'(i + 1));
            if (i < 5) drive(64'(i + 2), 2'd0, 1'b1);
            else in_valid = 1'b0;
        end
        step();
        chk("rr.xfer_cnt", {32'd0, xfer_cnt}, 64'd6);

        // Explicit destination
        ch_ready = 4'b0100;
        drive(64'hDEAD_BEEF_0000_0001, 2'd2, 1'b0);
        step();
        in_valid = 1'b0;
        chk("explicit.sel_out", {62'd0, sel_out}, 64'd2);
        chk("explicit.ch_valid", {60'd0, ch_valid}, 64'h4);
        chk("explicit.d_out", d_out, 64'hDEAD_BEEF_0000_0001);
        step();
        chk("explicit.xfer_cnt", {32'd0, xfer_cnt}, 64'd7);

        // Backpressure: A held, B in skid, C held off
        ch_ready = 4'h0;
        drive(64'hA, 2'd1, 1'b0);
        step();
        drive(64'hB, 2'd1, 1'b0);
        step();
        chk("bp.in_ready_full", {63'd0, in_ready}, 64'd0);
        chk("bp.hold_A", d_out, 64'hA);
        drive(64'hC, 2'd1, 1'b0);
        step();
        chk("bp.still_full", {63'd0, in_ready}, 64'd0);
        chk("bp.stable_A", d_out, 64'hA);
        ch_ready = 4'hF;
        step();
        chk("bp.B_out", d_out, 64'hB);
        chk("bp.ready_back", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp.C_out", d_out, 64'hC);
        step();
        chk("bp.empty", {60'd0, ch_valid}, 64'd0);
        chk("bp.xfer_cnt", {32'd0, xfer_cnt}, 64'd10);

        // Reset mid-stream with both registers full
        ch_ready = 4'h0;
        drive(64'h51, 2'd0, 1'b1);
        step();
        drive(64'h52, 2'd0, 1'b1);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst.ch_valid", {60'd0, ch_valid}, 64'd0);
        chk("midrst.d_out", d_out, 64'd0);
        chk("midrst.in_ready", {63'd0, in_ready}, 64'd0);
        chk("midrst.xfer_cnt", {32'd0, xfer_cnt}, 64'd0);
        step();
        rst = 1'b0;

        // Mixed modes: rr_ptr restarts at 0 and skips the explicit word
        ch_ready = 4'hF;
        drive(64'h61, 2'd0, 1'b1);
        step();
        chk("mixed.sel0", {62'd0, sel_out}, 64'd0);
        drive(64'h62, 2'd3, 1'b0);
        step();
        chk("mixed.sel1", {62'd0, sel_out}, 64'd3);
        drive(64'h63, 2'd0, 1'b1);
        step();
        chk("mixed.sel2", {62'd0, sel_out}, 64'd1);
        in_valid = 1'b0;
        step();

        // Patterned backpressure with alternating modes, checked by the model
        for (int i = 0; i < 16; i++) begin
            ch_ready = pat[i];
            in_valid = (i % 3) != 2;
            in_data  = 64'h100 + 64'(i);
            in_dest  = 2'(i);
            in_mode  = i[0];
            step();
        end
        in_valid = 1'b0;
        ch_ready = 4'hF;
        step(); step(); step();

        // Counter wrap
        force dut.r_xfer_cnt = 32'hFFFF_FFFF;
        m_base = 32'hFFFF_FFFF - m_fires;
        #1;
        release dut.r_xfer_cnt;
        #1;
        chk("wrap.preload", {32'd0, xfer_cnt}, 64'hFFFF_FFFF);
        step();
        drive(64'h77, 2'd2, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("wrap.zero", {32'd0, xfer_cnt}, 64'd0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
